// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cam_pkg
// Purpose : Shared constants and types for the camera post-processing block:
//           frame size, index width, IEEE-754 single-precision field layout
//           and the converter FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package cam_pkg;

    // Channels per frame: 25 x 25 pixels x 3 colour channels
    localparam int N_PIX       = 1875;
    localparam int IDX_W       = 11;

    // float32 field layout
    localparam int FP_W        = 32;
    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_MANT_MSB = 22;
    localparam int FP_MANT_W   = 23;
    localparam int FP_EXP_BIAS = 127;

    // Output channel width
    localparam int OUT_W       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/float32_to_uint4.sv
`default_nettype none
// ============================================================================
// Module  : float32_to_uint4
// Purpose : Combinational float32 -> uint4 decode. The value is scaled by
//           2^SCALE_EXP and truncated toward zero, saturating at 15.
//           Negatives, zeros, denormals and NaN decode to 0; +Inf to 15.
// Ports   : f      in  32  float32 input
//           result out 4   decoded unsigned channel
// Revision: 1.0 - initial release
// ============================================================================
module float32_to_uint4
    import cam_pkg::*;
#(
    parameter int SCALE_EXP = 4
) (
    input  logic [FP_W-1:0]  f,
    output logic [OUT_W-1:0] result
);

    // Unbiased exponent plus the decode scale, folded into one constant
    localparam logic signed [9:0] X_OFFSET = 10'(SCALE_EXP - FP_EXP_BIAS);

    logic                  sign;
    logic [7:0]            expo;
    logic [FP_MANT_W-1:0]  mant;
    logic signed [9:0]     x;
    logic [FP_MANT_W:0]    mant_full;
    logic [4:0]            shamt;

    assign sign      = f[FP_SIGN_BIT];
    assign expo      = f[FP_EXP_MSB:FP_EXP_LSB];
    assign mant      = f[FP_MANT_MSB:0];
    assign x         = $signed({2'b00, expo}) + X_OFFSET;
    assign mant_full = {1'b1, mant};
    // Only meaningful when 0 <= x <= 3, giving a shift of 20..23
    assign shamt     = 5'(FP_MANT_W) - x[4:0];

    always_comb begin
        result = '0;
        if (sign) begin
            result = '0;
        end else if (expo == 8'd0) begin
            result = '0;
        end else if (expo == 8'hFF) begin
            result = (mant == '0) ? 4'd15 : 4'd0;
        end else if (x < 10'sd0) begin
            result = '0;
        end else if (x >= 10'sd4) begin
            result = 4'd15;
        end else begin
            result = 4'(mant_full >> shamt);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cam_postprocess.sv
`default_nettype none
// ============================================================================
// Module  : cam_postprocess
// Purpose : Converts a flat frame of float32 channels into 4-bit channels,
//           one channel per cycle through a 2-stage pipeline
//           (stage 1: select + register, stage 2: decode + slice write).
// Ports   : clk    in   1         clock, rising edge
//           rst_n  in   1         asynchronous active-low reset
//           in     in   N_PIX*32  float32 frame, element j at [j*32 +: 32]
//           start  in   1         level-sampled (re)start request
//           out    out  N_PIX*4   uint4 frame, element j at [j*4 +: 4]
//           busy   out  1         conversion in progress
//           finish out  1         sticky done flag, cleared by start
// Revision: 1.0 - initial release
// ============================================================================
module cam_postprocess
    import cam_pkg::*;
#(
    parameter int N_PIX     = cam_pkg::N_PIX,
    parameter int SCALE_EXP = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_PIX*FP_W-1:0]  in,
    input  logic                   start,
    output logic [N_PIX*OUT_W-1:0] out,
    output logic                   busy,
    output logic                   finish
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic               capture;
    logic               write_en;

    logic               s1_valid;
    logic [FP_W-1:0]    s1_data;
    logic [IDX_W-1:0]   s1_idx;

    logic [FP_W-1:0]    in_sel;
    logic [OUT_W-1:0]   conv_result;

    // ------------------------------------------------------------------
    // FSM next-state / issue logic. start overrides every state.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        capture   = 1'b0;
        if (start) begin
            state_nxt = RUN;
            idx_nxt   = '0;
        end else begin
            case (state)
                RUN: begin
                    capture = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_nxt = DRAIN;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
                DRAIN:   state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // A start edge discards whatever sits in stage 1
    assign write_en = s1_valid && !start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    assign busy   = (state == RUN) || (state == DRAIN);
    assign finish = (state == DONE);

    // ------------------------------------------------------------------
    // Stage 1: input mux and capture
    // ------------------------------------------------------------------
    assign in_sel = in[{idx, 5'b00000} +: FP_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= capture;
            if (capture) begin
                s1_data <= in_sel;
                s1_idx  <= idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: decode and write a single output slice
    // ------------------------------------------------------------------
    float32_to_uint4 #(
        .SCALE_EXP (SCALE_EXP)
    ) u_conv (
        .f      (s1_data),
        .result (conv_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else if (write_en) begin
            out[{s1_idx, 2'b00} +: OUT_W] <= conv_result;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cam_postprocess.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_cam_postprocess
// Purpose : Self-checking bench for cam_postprocess: table-driven frame of
//           known encodings, random frames against a real-arithmetic
//           reference, async reset, and mid-frame restart sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cam_postprocess;

    localparam int N  = 1875;
    localparam int NV = 27;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [N*32-1:0]   in_bus;
    logic [N*4-1:0]    out_bus;
    logic              busy;
    logic              finish;

    int errors = 0;
    int checks = 0;

    int exp_cur [N];
    int exp_old [N];

    typedef struct {
        logic [31:0] f;
        int          exp;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    cam_postprocess #(
        .N_PIX     (N),
        .SCALE_EXP (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in_bus),
        .start  (start),
        .out    (out_bus),
        .busy   (busy),
        .finish (finish)
    );

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Reference: value * 16 computed in real arithmetic, floored, clamped
    function automatic int ref_conv(input logic [31:0] f);
        int  e;
        real v;
        e = int'(f[30:23]);
        if (f[31])    return 0;
        if (e == 0)   return 0;
        if (e == 255) return (f[22:0] == 23'd0) ? 15 : 0;
        v = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127)) * 16.0;
        if (v >= 16.0) return 15;
        return int'($floor(v));
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 7) < 6) begin
            r[30:23] = 8'($urandom_range(119, 132));
            r[31]    = ($urandom_range(0, 9) == 0);
        end
        return r;
    endfunction

    task automatic load_table();
        for (int j = 0; j < N; j++) begin
            in_bus[j*32 +: 32] = vecs[j % NV].f;
            exp_cur[j]         = vecs[j % NV].exp;
        end
    endtask

    task automatic load_random();
        logic [31:0] f;
        for (int j = 0; j < N; j++) begin
            f                  = rand_float();
            in_bus[j*32 +: 32] = f;
            exp_cur[j]         = ref_conv(f);
        end
    endtask

    // start high for 'hold' rising edges; returns at the negedge after T0
    task automatic pulse_start(input int hold);
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i < hold; i++) @(negedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_finish(input string name);
        int   cyc;
        logic busy_before;
        bit   seen;
        cyc         = 0;
        busy_before = 1'b0;
        seen        = 1'b0;
        check({name, " busy after start"},   int'(busy),   1);
        check({name, " finish after start"}, int'(finish), 0);
        while (!seen && cyc < N + 20) begin
            @(posedge clk);
            cyc++;
            #1;
            if (finish) seen = 1'b1;
            else        busy_before = busy;
        end
        check({name, " cycles T0 to finish"}, seen ? cyc : -1, N + 1);
        check({name, " busy at finish"},      int'(busy),      0);
        check({name, " busy before finish"},  int'(busy_before), 1);
    endtask

    task automatic check_range(input string name, input int lo, input int hi,
                               input int expv [N]);
        for (int j = lo; j <= hi; j++) begin
            check($sformatf("%s slice %0d", name, j), int'(out_bus[j*4 +: 4]), expv[j]);
        end
    endtask

    initial begin
        // pattern frame
        vecs[0]  = '{32'h3D800000, 1};
        vecs[1]  = '{32'h3F000000, 8};
        vecs[2]  = '{32'h3F700000, 15};
        vecs[3]  = '{32'h3DC00000, 1};
        // saturation / specials
        vecs[4]  = '{32'h3F800000, 15};
        vecs[5]  = '{32'h7F800000, 15};
        vecs[6]  = '{32'h7FC00000, 0};
        vecs[7]  = '{32'hBF000000, 0};
        vecs[8]  = '{32'h80000000, 0};
        vecs[9]  = '{32'h00000001, 0};
        vecs[10] = '{32'h3C800000, 0};
        // round trip k * 2^-4
        vecs[11] = '{32'h00000000, 0};
        vecs[12] = '{32'h3D800000, 1};
        vecs[13] = '{32'h3E000000, 2};
        vecs[14] = '{32'h3E400000, 3};
        vecs[15] = '{32'h3E800000, 4};
        vecs[16] = '{32'h3EA00000, 5};
        vecs[17] = '{32'h3EC00000, 6};
        vecs[18] = '{32'h3EE00000, 7};
        vecs[19] = '{32'h3F000000, 8};
        vecs[20] = '{32'h3F100000, 9};
        vecs[21] = '{32'h3F200000, 10};
        vecs[22] = '{32'h3F300000, 11};
        vecs[23] = '{32'h3F400000, 12};
        vecs[24] = '{32'h3F500000, 13};
        vecs[25] = '{32'h3F600000, 14};
        vecs[26] = '{32'h3F700000, 15};

        in_bus = '0;

        // Reset state
        #3;
        check("reset out zero", int'(out_bus == '0), 1);
        check("reset busy",     int'(busy),   0);
        check("reset finish",   int'(finish), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table frame, single-cycle start pulse
        load_table();
        pulse_start(1);
        wait_finish("table");
        check_range("table", 0, N - 1, exp_cur);

        // Async reset with a populated out, checked before the next clk edge
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset out zero", int'(out_bus == '0), 1);
        check("async reset finish",   int'(finish), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random frame, reset asserted at idx = 1000, then rerun
        load_random();
        pulse_start(1);
        repeat (1000) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun reset out zero", int'(out_bus == '0), 1);
        check("midrun reset busy",     int'(busy),   0);
        check("midrun reset finish",   int'(finish), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start(1);
        wait_finish("random after reset");
        check_range("random after reset", 0, N - 1, exp_cur);

        // Restart at idx = 500 with a different frame, start held 2 cycles
        exp_old = exp_cur;
        load_table();
        pulse_start(1);
        repeat (500) @(posedge clk);
        exp_cur = '{default: 0};
        for (int j = 0; j < N; j++) exp_old[j] = (j <= 498) ? vecs[j % NV].exp : exp_old[j];
        load_random();
        pulse_start(2);
        check_range("restart held old", 0, N - 1, exp_old);
        wait_finish("restart");
        check_range("restart new", 0, N - 1, exp_cur);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
